// File: rtl/turtle_event_gen_pkg.sv
// Shared definitions for the turtle event generator: coordinate widths, collapsion
// FSM encodings, orientation constants and the 12-bit box helper.
package turtle_event_gen_pkg;

  localparam int COORD_W = 11;
  localparam int EDGE_W  = 12;
  localparam int CNT_W   = 16;

  localparam logic [0:0] COL_ARMED = 1'b0;
  localparam logic [0:0] COL_WAIT  = 1'b1;

  localparam logic ORIENT_RIGHT = 1'b0;
  localparam logic ORIENT_LEFT  = 1'b1;

  typedef struct packed {
    logic [EDGE_W-1:0] left;
    logic [EDGE_W-1:0] top;
    logic [EDGE_W-1:0] right;
    logic [EDGE_W-1:0] bottom;
  } box_t;

  // Edges are widened to 12 bits so x+w / y+h never wrap.
  function automatic box_t make_box(input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] y,
                                    input logic [COORD_W-1:0] w,
                                    input logic [COORD_W-1:0] h);
    box_t b;
    b.left   = {1'b0, x};
    b.top    = {1'b0, y};
    b.right  = {1'b0, x} + {1'b0, w};
    b.bottom = {1'b0, y} + {1'b0, h};
    return b;
  endfunction

endpackage

// File: rtl/turtle_event_gen_rect_overlap.sv
// Combinational strict box intersection on 12-bit edges; boxes that only touch
// along an edge do not overlap.
module turtle_event_gen_rect_overlap
  import turtle_event_gen_pkg::*;
(
  input  box_t a,
  input  box_t b,
  output logic hit
);

  assign hit = (a.left < b.right) && (b.left < a.right) &&
               (a.top < b.bottom) && (b.top < a.bottom);

endmodule

// File: rtl/turtle_event_gen.sv
// Per-frame turtle event generator: wall collapsion FSM, stomp/side contact with
// cooldown, and walk animation toggle. Optional feature macro: TURTLE_SHELL_KICK_EN.
module turtle_event_gen
  import turtle_event_gen_pkg::*;
#(
  parameter int unsigned X_MIN        = 0,
  parameter int unsigned X_MAX        = 640,
  parameter int unsigned STOMP_MARGIN = 4,
  parameter int unsigned STOMP_CD     = 8,
  parameter int unsigned WALK_DIV     = 6,
  parameter int unsigned COL_TIMEOUT  = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               frame_tick,
  input  logic               active,
  input  logic [COORD_W-1:0] turtle_x,
  input  logic [COORD_W-1:0] turtle_y,
  input  logic [COORD_W-1:0] turtle_w,
  input  logic [COORD_W-1:0] turtle_h,
  input  logic               oriental,
  input  logic               shell,
  input  logic [COORD_W-1:0] mario_x,
  input  logic [COORD_W-1:0] mario_y,
  input  logic [COORD_W-1:0] mario_w,
  input  logic [COORD_W-1:0] mario_h,
  input  logic               mario_falling,
  output logic               collapsion_impulse,
  output logic               press_impulse,
  output logic               clk_walk_anim,
  output logic               mario_hurt,
  output logic               mario_bounce,
  output logic [0:0]         dbg_col_state
);

  localparam logic [EDGE_W-1:0] X_MIN_E   = EDGE_W'(X_MIN);
  localparam logic [EDGE_W-1:0] X_MAX_E   = EDGE_W'(X_MAX);
  localparam logic [EDGE_W-1:0] MARGIN_E  = EDGE_W'(STOMP_MARGIN);
  localparam logic [CNT_W-1:0]  WALK_LAST = CNT_W'(WALK_DIV - 1);
  localparam logic [CNT_W-1:0]  COL_TO    = CNT_W'(COL_TIMEOUT);
  localparam logic [CNT_W-1:0]  CD_LOAD   = CNT_W'(STOMP_CD);

  logic [CNT_W-1:0] walk_cnt_q, walk_cnt_d;
  logic             walk_anim_q, walk_anim_d;
  logic [0:0]       col_state_q, col_state_d;
  logic             col_orient_q, col_orient_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             col_imp_q, col_imp_d;
  logic [CNT_W-1:0] cd_cnt_q, cd_cnt_d;
  logic             press_imp_q, press_imp_d;
  logic             hurt_q, hurt_d;
  logic             bounce_q, bounce_d;

  box_t t_box;
  box_t m_box;
  logic overlap;
  logic eval;
  logic wall_hit;
  logic stomp;
  logic side;
  logic [EDGE_W-1:0] stomp_line;
  logic [CNT_W-1:0]  wait_next;

  assign t_box = make_box(turtle_x, turtle_y, turtle_w, turtle_h);
  assign m_box = make_box(mario_x, mario_y, mario_w, mario_h);

  turtle_event_gen_rect_overlap u_overlap (
    .a   (m_box),
    .b   (t_box),
    .hit (overlap)
  );

  assign eval       = frame_tick && active;
  assign stomp_line = t_box.top + MARGIN_E;
  assign stomp      = overlap && mario_falling && (m_box.bottom <= stomp_line);
  assign side       = overlap && !stomp;
  assign wall_hit   = ((oriental == ORIENT_LEFT)  && (t_box.left  <= X_MIN_E)) ||
                      ((oriental == ORIENT_RIGHT) && (t_box.right >= X_MAX_E));
  assign wait_next  = wait_cnt_q + CNT_W'(1);

  always_comb begin
    walk_cnt_d   = walk_cnt_q;
    walk_anim_d  = walk_anim_q;
    col_state_d  = col_state_q;
    col_orient_d = col_orient_q;
    wait_cnt_d   = wait_cnt_q;
    col_imp_d    = col_imp_q;
    cd_cnt_d     = cd_cnt_q;
    press_imp_d  = press_imp_q;
    hurt_d       = 1'b0;
    bounce_d     = 1'b0;

    if (eval) begin
      if (walk_cnt_q >= WALK_LAST) begin
        walk_cnt_d  = '0;
        walk_anim_d = ~walk_anim_q;
      end else begin
        walk_cnt_d = walk_cnt_q + CNT_W'(1);
      end

      // wait_cnt counts WAIT frames including the entry frame.
      case (col_state_q)
        COL_ARMED: begin
          if (wall_hit) begin
            col_state_d  = COL_WAIT;
            col_imp_d    = ~col_imp_q;
            col_orient_d = oriental;
            wait_cnt_d   = CNT_W'(1);
          end
        end
        COL_WAIT: begin
          wait_cnt_d = wait_next;
          if ((oriental != col_orient_q) || (wait_next >= COL_TO)) begin
            col_state_d = COL_ARMED;
          end
        end
        default: col_state_d = COL_ARMED;
      endcase

      if (cd_cnt_q != '0) begin
        cd_cnt_d = cd_cnt_q - CNT_W'(1);
      end else if (stomp) begin
        press_imp_d = ~press_imp_q;
        bounce_d    = 1'b1;
        cd_cnt_d    = CD_LOAD;
      end else if (side && !shell) begin
        hurt_d   = 1'b1;
        cd_cnt_d = CD_LOAD;
      end
`ifdef TURTLE_SHELL_KICK_EN
      else if (side && shell) begin
        press_imp_d = ~press_imp_q;
        cd_cnt_d    = CD_LOAD;
      end
`else
      else begin
        cd_cnt_d = cd_cnt_q;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      walk_cnt_q   <= '0;
      walk_anim_q  <= 1'b0;
      col_state_q  <= COL_ARMED;
      col_orient_q <= 1'b0;
      wait_cnt_q   <= '0;
      col_imp_q    <= 1'b0;
      cd_cnt_q     <= '0;
      press_imp_q  <= 1'b0;
      hurt_q       <= 1'b0;
      bounce_q     <= 1'b0;
    end else begin
      walk_cnt_q   <= walk_cnt_d;
      walk_anim_q  <= walk_anim_d;
      col_state_q  <= col_state_d;
      col_orient_q <= col_orient_d;
      wait_cnt_q   <= wait_cnt_d;
      col_imp_q    <= col_imp_d;
      cd_cnt_q     <= cd_cnt_d;
      press_imp_q  <= press_imp_d;
      hurt_q       <= hurt_d;
      bounce_q     <= bounce_d;
    end
  end

  assign collapsion_impulse = col_imp_q;
  assign press_impulse      = press_imp_q;
  assign clk_walk_anim      = walk_anim_q;
  assign mario_hurt         = hurt_q;
  assign mario_bounce       = bounce_q;
  assign dbg_col_state      = col_state_q;

endmodule
